// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU sequencer: opcodes, condition codes,
// instruction field positions and the sequencer state encoding.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ARITH_MAX = 4'h7;
  localparam logic [3:0] OP_CMP       = 4'hB;
  localparam logic [3:0] OP_MOV       = 4'hD;
  localparam logic [3:0] OP_STR       = 4'hE;

  localparam logic [3:0] CC_AL = 4'h0;
  localparam logic [3:0] CC_EQ = 4'h1;
  localparam logic [3:0] CC_GT = 4'h2;
  localparam logic [3:0] CC_LT = 4'h3;
  localparam logic [3:0] CC_GE = 4'h4;
  localparam logic [3:0] CC_LE = 4'h5;
  localparam logic [3:0] CC_HI = 4'h6;
  localparam logic [3:0] CC_LO = 4'h7;
  localparam logic [3:0] CC_HS = 4'h8;

  localparam int COND_LSB = 28;
  localparam int OPC_LSB  = 24;
  localparam int S_BIT    = 23;
  localparam int SRC_LSB  = 20;
  localparam int RD_LSB   = 16;
  localparam int RN_LSB   = 12;
  localparam int RM_LSB   = 8;
  localparam int SRB_LSB  = 3;
  localparam int IMM_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_OPER = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  // Reserved opcodes fall through to the range test and are rejected.
  function automatic logic wr_eligible(input logic [3:0] op);
    case (op)
      OP_CMP, OP_STR: return 1'b0;
      OP_MOV:         return 1'b1;
      default:        return op <= OP_ARITH_MAX;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, register-file and ALU control bundle between the
// sequencer (master) and its surrounding datapath (slave).
interface alu_sequencer_if;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [3:0]  RdAddrA;
  logic [3:0]  RdAddrB;
  logic [31:0] RdDataA;
  logic [31:0] RdDataB;
  logic [31:0] AluIn1;
  logic [31:0] AluIn2;
  logic [3:0]  AluOpcode;
  logic [3:0]  AluCond;
  logic        AluS;
  logic [2:0]  AluSR_Cont;
  logic [4:0]  AluSR_Bit;
  logic [15:0] AluImm;
  logic [31:0] AluOut;
  logic [3:0]  AluFlags;
  logic        WrEn;
  logic [3:0]  WrAddr;
  logic [31:0] WrData;

  modport master (
    input  InstrValid, Instr, RdDataA, RdDataB, AluOut, AluFlags,
    output InstrReady, RdAddrA, RdAddrB, AluIn1, AluIn2, AluOpcode, AluCond,
           AluS, AluSR_Cont, AluSR_Bit, AluImm, WrEn, WrAddr, WrData
  );

  modport slave (
    output InstrValid, Instr, RdDataA, RdDataB, AluOut, AluFlags,
    input  InstrReady, RdAddrA, RdAddrB, AluIn1, AluIn2, AluOpcode, AluCond,
           AluS, AluSR_Cont, AluSR_Bit, AluImm, WrEn, WrAddr, WrData
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational condition check on the two operands, using the ALU's codes.
module cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic [3:0]  Cond,
  output logic        CondMet
);
  always_comb begin
    CondMet = 1'b0;
    case (Cond)
      CC_AL:   CondMet = 1'b1;
      CC_EQ:   CondMet = In1 == In2;
      CC_GT:   CondMet = $signed(In1) >  $signed(In2);
      CC_LT:   CondMet = $signed(In1) <  $signed(In2);
      CC_GE:   CondMet = $signed(In1) >= $signed(In2);
      CC_LE:   CondMet = $signed(In1) <= $signed(In2);
      CC_HI:   CondMet = In1 >  In2;
      CC_LO:   CondMet = In1 <  In2;
      CC_HS:   CondMet = In1 >= In2;
      default: CondMet = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_sequencer.sv
// Five-state single-issue sequencer: fetch operands from the register file,
// drive an external ALU, write back the result and update the flag register.
module alu_sequencer
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.master   bus,
  output logic [3:0]        Flags,
  output logic              Busy
);
  state_t      state, state_nx;
  logic [31:0] ir, op_a, op_b, alu_out_q;
  logic [3:0]  alu_flags_q, rd_addr_a, rd_addr_b;
  logic [3:0]  alu_opcode, alu_cond;
  logic        alu_s;
  logic [2:0]  alu_src;
  logic [4:0]  alu_srb;
  logic [15:0] alu_imm;
  logic        cond_met, flag_upd, accept;

  cond_eval u_cond (
    .In1     (op_a),
    .In2     (op_b),
    .Cond    (alu_cond),
    .CondMet (cond_met)
  );

  assign accept   = (state == ST_IDLE) && bus.InstrValid;
  assign flag_upd = cond_met && (alu_s || alu_opcode == OP_CMP);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.InstrReady = 1'b0;
    Busy           = 1'b1;
    bus.WrEn       = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.InstrReady = 1'b1;
        Busy           = 1'b0;
        if (bus.InstrValid) state_nx = ST_READ;
      end
      ST_READ: state_nx = ST_OPER;
      ST_OPER: state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_WB;
      ST_WB: begin
        bus.WrEn = cond_met && wr_eligible(alu_opcode);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Every datapath register loads only in its own state, so all ALU and
  // read-address outputs hold their values for the rest of the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir          <= '0;
      op_a        <= '0;
      op_b        <= '0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      alu_opcode  <= '0;
      alu_cond    <= '0;
      alu_s       <= 1'b0;
      alu_src     <= '0;
      alu_srb     <= '0;
      alu_imm     <= '0;
      alu_out_q   <= '0;
      alu_flags_q <= '0;
      Flags       <= '0;
    end else begin
      if (accept) begin
        ir        <= bus.Instr;
        rd_addr_a <= bus.Instr[RN_LSB +: 4];
        rd_addr_b <= bus.Instr[RM_LSB +: 4];
      end
      if (state == ST_OPER) begin
        op_a       <= bus.RdDataA;
        op_b       <= bus.RdDataB;
        alu_opcode <= ir[OPC_LSB +: 4];
        alu_cond   <= ir[COND_LSB +: 4];
        alu_s      <= ir[S_BIT];
        alu_src    <= ir[SRC_LSB +: 3];
        alu_srb    <= ir[SRB_LSB +: 5];
        alu_imm    <= ir[IMM_LSB +: 16];
      end
      if (state == ST_EXEC) begin
        alu_out_q   <= bus.AluOut;
        alu_flags_q <= bus.AluFlags;
      end
      if (state == ST_WB && flag_upd) Flags <= alu_flags_q;
    end
  end

  assign bus.RdAddrA    = rd_addr_a;
  assign bus.RdAddrB    = rd_addr_b;
  assign bus.AluIn1     = op_a;
  assign bus.AluIn2     = op_b;
  assign bus.AluOpcode  = alu_opcode;
  assign bus.AluCond    = alu_cond;
  assign bus.AluS       = alu_s;
  assign bus.AluSR_Cont = alu_src;
  assign bus.AluSR_Bit  = alu_srb;
  assign bus.AluImm     = alu_imm;
  assign bus.WrAddr     = ir[RD_LSB +: 4];
  assign bus.WrData     = alu_out_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: a register file and ALU model surround the sequencer; the
// driver predicts each accepted instruction, the monitor checks write-backs.
module tb_alu_sequencer;
  import alu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Flags;
  logic       Busy;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .Flags (Flags),
    .Busy  (Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  flags;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0, n_err = 0, cyc = 0;
  logic [31:0] rf[16];
  logic [31:0] mregs[16];
  logic [3:0]  mflags = 4'h0;
  logic        set_en = 1'b0;
  logic [3:0]  set_idx = 4'h0;
  logic [31:0] set_val = 32'h0;
  int          chk_req = 0, chk_done = 0;
  bit          drv_to = 0, end_req = 0, end_done = 0, stream_mode = 0;

  // ALU model: {N, Z, C, V=0, result}
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [15:0] imm);
    logic [32:0] r;
    case (op)
      4'h0:       r = {1'b0, a} + {1'b0, b};
      4'h1, 4'hB: r = {1'b0, a} - {1'b0, b};
      4'h2:       r = {1'b0, a & b};
      4'h3:       r = {1'b0, a | b};
      4'h4:       r = {1'b0, a ^ b};
      4'h5:       r = {1'b0, a << b[4:0]};
      4'h6:       r = {1'b0, a >> b[4:0]};
      4'h7:       r = {1'b0, a} + {17'b0, imm};
      4'hD:       r = {17'b0, imm};
      default:    r = {1'b0, a};
    endcase
    return {r[31], r[31:0] == 32'h0, r[32], 1'b0, r[31:0]};
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (c)
      4'h0:    return 1;
      4'h1:    return a == b;
      4'h2:    return sa > sb;
      4'h3:    return sa < sb;
      4'h4:    return sa >= sb;
      4'h5:    return sa <= sb;
      4'h6:    return a > b;
      4'h7:    return a < b;
      4'h8:    return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op, input logic s,
                                     input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm);
    return {c, op, s, 3'b0, rd, rn, rm, 8'h0};
  endfunction

  assign {bus.AluFlags, bus.AluOut} = alu_fn(bus.AluOpcode, bus.AluIn1, bus.AluIn2, bus.AluImm);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.WrEn)     rf[bus.WrAddr] <= bus.WrData;
    else if (set_en)  rf[set_idx] <= set_val;
    bus.RdDataA <= rf[bus.RdAddrA];
    bus.RdDataB <= rf[bus.RdAddrB];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  bit   prev_busy = 0, saw_wr = 0, have_acc = 0;
  int   last_acc = 0;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 0;
      saw_wr    = 0;
      have_acc  = 0;
    end else begin
      if (bus.WrEn) begin
        saw_wr = 1;
        chk("wr_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("wr_addr", bus.WrAddr, q[0].addr);
          chk("wr_data", bus.WrData, q[0].data);
          chk("wr_latency", cyc + 1, q[0].acc + 4);
        end
      end
      if (prev_busy && !Busy) begin
        chk("done_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("wr_count", saw_wr, e.wr);
          chk("flags", Flags, e.flags);
          chk("done_latency", cyc, e.acc + 4);
          chk("ready_after", bus.InstrReady, 1);
        end
        saw_wr = 0;
      end
      if (!stream_mode) have_acc = 0;
      if (bus.InstrReady && bus.InstrValid) begin
        if (have_acc) chk("accept_spacing", cyc + 1 - last_acc, 5);
        last_acc = cyc + 1;
      have_acc = stream_mode;
      end
      if (chk_req != chk_done) begin
        chk("rst_flags", Flags, 0);
        chk("rst_ready", bus.InstrReady, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_wren", bus.WrEn, 0);
        chk("rst_alu_ctrl", {bus.AluOpcode, bus.AluCond, bus.AluS, bus.AluSR_Cont, bus.AluSR_Bit}, 0);
        chk("rst_alu_in", bus.AluIn1 | bus.AluIn2, 0);
        chk("rst_alu_imm", bus.AluImm, 0);
        chk("rst_rdaddr", {bus.RdAddrA, bus.RdAddrB}, 0);
        chk("rst_wrdata", bus.WrData, 0);
        chk_done = chk_req;
      end
      if (end_req && !end_done) begin
        chk("sb_empty", q.size(), 0);
        chk("drv_timeout", drv_to, 0);
        end_done = 1;
      end
      prev_busy = Busy;
    end
  end

  // ---------------- driver / reference model ----------------
  task automatic predict(input logic [31:0] ins);
    logic [3:0]  c  = ins[31:28];
    logic [3:0]  op = ins[27:24];
    logic [3:0]  rd = ins[19:16];
    logic [3:0]  rn = ins[15:12];
    logic [3:0]  rm = ins[11:8];
    logic [35:0] r;
    bit          met;
    exp_t        x;
    met  = cond_ok(c, mregs[rn], mregs[rm]);
    r    = alu_fn(op, mregs[rn], mregs[rm], ins[15:0]);
    x.wr = met && (op <= 4'h7 || op == 4'hD);
    if (x.wr) mregs[rd] = r[31:0];
    if (met && (ins[23] || op == 4'hB)) mflags = r[35:32];
    x.addr  = rd;
    x.data  = r[31:0];
    x.flags = mflags;
    x.acc   = cyc + 1;
    q.push_back(x);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (Busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (Busy) drv_to = 1;
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    wait_idle();
    @(posedge clk); #1;
    set_en   = 1'b1;
    set_idx  = i[3:0];
    set_val  = v;
    mregs[i] = v;
    @(posedge clk); #1;
    set_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins);
    int t = 0;
    @(posedge clk); #1;
    bus.InstrValid = 1'b1;
    bus.Instr      = ins;
    @(negedge clk);
    while (!bus.InstrReady && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (bus.InstrReady) predict(ins);
    else drv_to = 1;
    @(posedge clk); #1;
    bus.InstrValid = 1'b0;
    bus.Instr      = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst    = 1'b1;
    q.delete();
    mflags = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_req++;
  endtask

  initial begin
    logic [31:0] ins;
    bus.InstrValid = 1'b0;
    bus.Instr      = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_req++;
    for (int i = 0; i < 16; i++) set_reg(i, $urandom);

    // ADD r3 = r1 + r2 with flag update
    set_reg(1, 32'd5);
    set_reg(2, 32'd7);
    send(mk(CC_AL, 4'h0, 1'b1, 4'd3, 4'd1, 4'd2));
    // SUB under GT that fails
    set_reg(9, 32'd100);
    send(mk(CC_GT, 4'h1, 1'b1, 4'd5, 4'd2, 4'd9));
    // unsigned HI passes where signed GT does not
    set_reg(4, 32'hFFFF_FFFF);
    set_reg(5, 32'd1);
    send(mk(CC_HI, 4'h0, 1'b1, 4'd6, 4'd4, 4'd5));
    send(mk(CC_GT, 4'h0, 1'b1, 4'd10, 4'd4, 4'd5));
    // CMP without S still sets flags; reserved opcode does nothing
    set_reg(7, 32'd4);
    set_reg(8, 32'd4);
    send(mk(CC_AL, OP_CMP, 1'b0, 4'd0, 4'd7, 4'd8));
    send(mk(CC_AL, 4'hF, 1'b1, 4'd11, 4'd7, 4'd8));
    // abort an instruction while it is in EXEC
    wait_idle();
    send(mk(CC_AL, 4'h0, 1'b1, 4'd12, 4'd1, 4'd2));
    @(posedge clk);
    do_reset();
    repeat (6) @(posedge clk);

    // InstrValid held high while Instr changes every cycle
    wait_idle();
    stream_mode = 1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      bus.InstrValid = 1'b1;
      bus.Instr      = $urandom;
      @(negedge clk);
      if (bus.InstrReady) predict(bus.Instr);
    end
    @(posedge clk); #1;
    bus.InstrValid = 1'b0;
    stream_mode    = 0;

    for (int k = 0; k < 40; k++) begin
      ins        = $urandom;
      ins[31:28] = 4'($urandom_range(0, 9));
      send(ins);
      if ($urandom_range(0, 3) == 0) set_reg(int'($urandom_range(0, 15)), 32'($urandom_range(0, 3)));
    end

    wait_idle();
    repeat (2) @(posedge clk);
    end_req = 1;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst  input  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-003 InstrValid  input  1  instruction offered.
REQ-004 InstrReady  output  1  sequencer can accept an instruction.
REQ-005 Instr  input  32  fields: Cond[31:28], Opcode[27:24], S[23], SR_Cont[22:20], Rd[19:16], Rn[15:12], Rm[11:8], SR_Bit[7:3], Immediate[15:0].
REQ-006 RdAddrA / RdAddrB  output  4 each  register-file read addresses (Rn, Rm).
REQ-007 RdDataA / RdDataB  input  32 each  register-file read data, valid one cycle after address.
REQ-008 AluIn1, AluIn2  output  32; AluOpcode, AluCond  output  4; AluS  output  1; AluSR_Cont  output  3; AluSR_Bit  output  5; AluImm  output  16  ALU controls.
REQ-009 AluOut  input  32; AluFlags  input  4  ALU result and flag outputs.
REQ-010 WrEn  output  1; WrAddr  output  4; WrData  output  32  register-file write port.
REQ-011 Flags  output  4  architectural flag register.
REQ-012 Busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, READ, OPER, EXEC, WB; one instruction in flight.
REQ-014 IDLE: InstrReady=1; InstrValid=1 latches Instr into the instruction register and moves to READ; otherwise stays in IDLE.
REQ-015 READ: RdAddrA=Rn, RdAddrB=Rm; unconditional move to OPER.
REQ-016 OPER: RdDataA/RdDataB are registered into operand registers; move to EXEC.
REQ-017 EXEC: all Alu* outputs are driven from registers and held stable; AluOut and AluFlags are sampled at the end of the cycle; move to WB.
REQ-018 WB: WrEn is a one-cycle pulse when write-eligible; then return to IDLE.
REQ-019 Handshake latency: acceptance edge at cycle N gives WrEn at cycle N+4; the next instruction can be accepted at cycle N+5.
REQ-020 Write-eligible opcodes: 0000-0111 and 1101, only when CondMet=1.
REQ-021 No write occurs for CMP (1011), STR (1110), reserved opcodes (1000, 1001, 1010, 1100, 1111), or CondMet=0.
REQ-022 CondMet is computed on the operand registers with the same codes as the ALU:
- 0000 always
- 0001 EQ; 0010 GT, 0011 LT, 0100 GE, 0101 LE (signed)
- 0110 HI, 0111 LO, 1000 HS (unsigned)
- 1001-1111 never.
REQ-023 Flags update in WB from the sampled AluFlags only when CondMet=1 and (S=1 or Opcode=1011); otherwise Flags hold.
REQ-024 WrData equals the sampled AluOut, never an undriven value; WrAddr = Rd.
REQ-025 Alu* outputs and RdAddr* hold their last values outside their active states.
REQ-026 InstrValid is ignored while Busy=1.

Reset
REQ-027 rst=1 forces the following on the next edge and dominates all other inputs: state IDLE, instruction and operand registers 0, Flags=0, WrEn=0, InstrReady=1, Busy=0, all Alu* and RdAddr* outputs 0.
REQ-028 Reset asserted in any state aborts the in-flight instruction: no WrEn and no Flags update afterwards.

Structure
REQ-029 Shared package alu_ctrl_pkg holds:
- opcode and condition-code constants
- instruction field bit positions
- the FSM state encoding.
REQ-030 Condition evaluation is a sub-module cond_eval (In1, In2, Cond -> CondMet), purely combinational.

Verification
REQ-031 Reset, then ADD Rd=3 with Rn=1 (5) and Rm=2 (7), S=1 -> one WrEn at N+4, WrAddr=3, WrData=12, Flags = ALU flags for 12.
REQ-032 SUB with Cond=GT, Rn=2, Rm=9 -> CondMet=0: no WrEn, Flags unchanged, InstrReady back at N+5.
REQ-033 Cond=HI with Rn=0xFFFFFFFF, Rm=1 -> executes (unsigned), while Cond=GT with the same operands does not execute.
REQ-034 CMP Rn=4, Rm=4, S=0 -> no WrEn and Flags updated (zero flag set); opcode 1111 -> no WrEn, no Flags change.
REQ-035 Assert rst during EXEC -> no WrEn follows, Flags=0, InstrReady=1 the cycle after reset deasserts.
REQ-036 Hold InstrValid=1 continuously with a changing Instr -> exactly one acceptance per 5 cycles; instructions offered while Busy are not latched.
